// File: rtl/led_matrix_pkg.sv
// Shared types and helpers for the LED-matrix scanner.
// Holds the matrix geometry, the scan FSM state type and the row-select decoder.
package led_matrix_pkg;

  localparam int ROWS  = 7;
  localparam int COLS  = 5;
  localparam int IDX_W = $clog2(ROWS);

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  typedef logic [COLS-1:0] row_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } row_sel_t;

  // Decode an active-low row select: valid only when exactly one bit is low.
  function automatic row_sel_t onehot_low_ok(input logic [ROWS-1:0] rowN);
    row_sel_t    sel;
    int unsigned zeros;
    sel   = '0;
    zeros = 0;
    for (int i = 0; i < ROWS; i++) begin
      if (!rowN[i]) begin
        zeros++;
        sel.idx = IDX_W'(i);
      end
    end
    sel.valid = (zeros == 1);
    return sel;
  endfunction

endpackage

// File: rtl/led_scan_timer.sv
// Scan timing for the LED matrix: slot counter, current row index and the
// BLANK/DRIVE state. Each row owns SCAN_DIV cycles; the first BLANK of them
// keep every row off so the previous row's charge can decay.
// The state type's BLANK literal shares its name with the BLANK parameter,
// so state values are always written with the package scope.
module led_scan_timer
  import led_matrix_pkg::*;
#(
  parameter int  SCAN_DIV = 1000,
  parameter int  BLANK    = 16,
  localparam int CNT_W    = $clog2(SCAN_DIV)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [CNT_W-1:0] cnt,
  output logic [IDX_W-1:0] idx,
  output scan_state_t      state,
  output logic             slot_end
);

  scan_state_t stateNext;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= led_matrix_pkg::BLANK;
    else        state <= stateNext;
  end

  // Slot counter and row index; the index advances and wraps at the end of each slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_W'(ROWS - 1)) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Next state: enter DRIVE as the counter reaches BLANK, back to BLANK at slot end.
  // NOTE: the default assignment first keeps this combinational block latch-free.
  always_comb begin
    stateNext = state;
    unique case (state)
      led_matrix_pkg::BLANK: if (cnt == CNT_W'(BLANK - 1)) stateNext = led_matrix_pkg::DRIVE;
      led_matrix_pkg::DRIVE: if (slot_end)                 stateNext = led_matrix_pkg::BLANK;
      default:                                             stateNext = led_matrix_pkg::BLANK;
    endcase
  end

  // Output decode: flag the last cycle of the current row slot.
  always_comb begin
    slot_end = (cnt == CNT_W'(SCAN_DIV - 1));
  end

endmodule

// File: rtl/led_matrix_scanner.sv
// 7x5 LED-matrix scanner: captures decoded rows into a frame buffer and
// time-multiplexes them onto the physical matrix with per-row blanking.
// Optional feature macro: SCAN_BRIGHTNESS_EN adds brightness_i[2:0], which
// shortens the column on-time within each DRIVE window (7 = full duty).
module led_matrix_scanner
  import led_matrix_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int BLANK    = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ROWS-1:0] row_n_i,
  input  row_t            col_i,
  input  logic            wr_en_i,
  input  logic            clear_i,
`ifdef SCAN_BRIGHTNESS_EN
  input  logic [2:0]      brightness_i,
`endif
  output logic [ROWS-1:0] row_n_o,
  output row_t            col_o,
  output logic            frame_full_o,
  output logic            err_o
);

  localparam int CNT_W = $clog2(SCAN_DIV);

  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  scan_state_t      state;
  logic             slotEnd;

  row_t             frameBuf [ROWS];
  logic [ROWS-1:0]  valid;
  logic [ROWS-1:0]  validNext;
  row_sel_t         rowSel;
  logic             writeOk;
  logic             writeBad;
  logic             dutyOn;
  logic [ROWS-1:0]  rowNext;
  row_t             colNext;
  logic             unusedScan;

  led_scan_timer #(
    .SCAN_DIV (SCAN_DIV),
    .BLANK    (BLANK)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .cnt      (cnt),
    .idx      (idx),
    .state    (state),
    .slot_end (slotEnd)
  );

  // Timing outputs the output path does not need in every build.
  assign unusedScan = ^{cnt, slotEnd};

  // Write decode: a clear suppresses both the write and its error pulse.
  always_comb begin
    rowSel    = onehot_low_ok(row_n_i);
    writeOk   = wr_en_i && !clear_i && rowSel.valid && (col_i != '0);
    writeBad  = wr_en_i && !clear_i && !(rowSel.valid && (col_i != '0));
    validNext = valid;
    if (clear_i)      validNext = '0;
    else if (writeOk) validNext[rowSel.idx] = 1'b1;
  end

  // Frame buffer storage, emptied by reset or clear.
  // NOTE: the buffer is reset along with the valid bits so no stale columns survive a reset; that makes it flops, not a RAM.
  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      for (int r = 0; r < ROWS; r++) frameBuf[r] <= '0;
    end else if (writeOk) begin
      frameBuf[rowSel.idx] <= col_i;
    end
  end

  // Valid bits, frame-full flag and the one-cycle reject pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid        <= '0;
      frame_full_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      valid        <= validNext;
      frame_full_o <= &validNext;
      err_o        <= writeBad;
    end
  end

`ifdef SCAN_BRIGHTNESS_EN
  // Column duty window: on for the first (brightness+1)/8 of the DRIVE window.
  always_comb begin
    dutyOn = ((32'(cnt) - 32'(BLANK)) * 32'd8) <
             ((32'(brightness_i) + 32'd1) * 32'(SCAN_DIV - BLANK));
  end
`else
  // Column duty window: full duty throughout DRIVE.
  always_comb begin
    dutyOn = 1'b1;
  end
`endif

  // Matrix drive decode from the scan state; everything off while blanking.
  always_comb begin
    rowNext = '1;
    colNext = '0;
    if (state == led_matrix_pkg::DRIVE) begin
      rowNext[idx] = 1'b0;
      if (dutyOn) colNext = frameBuf[idx];
    end
  end

  // Registered matrix drive, one stage behind the scan state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_n_o <= '1;
      col_o   <= '0;
    end else begin
      row_n_o <= rowNext;
      col_o   <= colNext;
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner with a short scan slot.
// After reset release, n counts clock edges taken out of reset; the drive
// seen after edge n belongs to slot (n-1)/SD, position (n-1)%SD.
module tb_led_matrix_scanner;

  localparam int SD = 24;
  localparam int BL = 4;
  localparam int NR = 7;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] row_n_i;
  logic [4:0]    col_i;
  logic          wr_en_i;
  logic          clear_i;
  logic [NR-1:0] row_n_o;
  logic [4:0]    col_o;
  logic          frame_full_o;
  logic          err_o;
`ifdef SCAN_BRIGHTNESS_EN
  logic [2:0]    brightness_i = 3'd7;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int n           = 0;

  logic [4:0] codes [NR];

  led_matrix_scanner #(
    .SCAN_DIV (SD),
    .BLANK    (BL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .row_n_i      (row_n_i),
    .col_i        (col_i),
    .wr_en_i      (wr_en_i),
    .clear_i      (clear_i),
`ifdef SCAN_BRIGHTNESS_EN
    .brightness_i (brightness_i),
`endif
    .row_n_o      (row_n_o),
    .col_o        (col_o),
    .frame_full_o (frame_full_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkOut(input string tag, input logic [NR-1:0] expRow, input logic [4:0] expCol);
    check({tag, "_row"}, 32'(row_n_o), 32'(expRow));
    check({tag, "_col"}, 32'(col_o), 32'(expCol));
  endtask

  // One clock edge; inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst_n) n++;
    @(negedge clk);
  endtask

  task automatic goTo(input int target);
    while (n < target) step();
  endtask

  task automatic writeRow(input int r, input logic [4:0] code);
    row_n_i = ~(7'(1) << r);
    col_i   = code;
    wr_en_i = 1'b1;
    step();
    wr_en_i = 1'b0;
    row_n_i = '1;
    col_i   = '0;
  endtask

  initial begin
    codes   = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b10001, 5'b01110};
    rst_n   = 1'b0;
    row_n_i = '1;
    col_i   = '0;
    wr_en_i = 1'b0;
    clear_i = 1'b0;

    // Reset held for three edges.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOut("reset", 7'h7F, 5'b00000);
    check("reset_full", 32'(frame_full_o), 32'd0);
    check("reset_err", 32'(err_o), 32'd0);
    rst_n = 1'b1;
    n     = 0;

    // Row 0 written, then shown only in its own DRIVE window.
    writeRow(0, 5'b00110);
    check("write_ok_err", 32'(err_o), 32'd0);
    goTo(4);  checkOut("row0_blank_last", 7'h7F, 5'b00000);
    goTo(5);  checkOut("row0_drive_first", 7'h7E, 5'b00110);
    goTo(24); checkOut("row0_drive_last", 7'h7E, 5'b00110);
    goTo(25); checkOut("row1_blank_first", 7'h7F, 5'b00000);
    goTo(29); checkOut("row1_unwritten", 7'h7D, 5'b00000);

    // Reject: two row bits low.
    row_n_i = 7'b1111100; col_i = 5'b11111; wr_en_i = 1'b1;
    step();
    check("rej_multi_err", 32'(err_o), 32'd1);
    check("rej_multi_col", 32'(col_o), 32'd0);
    wr_en_i = 1'b0; row_n_i = '1; col_i = '0;
    step();
    check("rej_multi_err_clr", 32'(err_o), 32'd0);

    // Reject: zero column code aimed at row 0.
    row_n_i = 7'b1111110; col_i = 5'b00000; wr_en_i = 1'b1;
    step();
    check("rej_zero_err", 32'(err_o), 32'd1);
    wr_en_i = 1'b0; row_n_i = '1;
    step();
    check("rej_zero_err_clr", 32'(err_o), 32'd0);

    // Write to the row currently in DRIVE: visible two edges later.
    writeRow(1, 5'b10101);
    check("live_write_lag", 32'(col_o), 32'd0);
    check("live_write_err", 32'(err_o), 32'd0);
    step();
    checkOut("live_write_show", 7'h7D, 5'b10101);

    // Reject: no row bit low.
    row_n_i = '1; col_i = 5'b11111; wr_en_i = 1'b1;
    step();
    check("rej_none_err", 32'(err_o), 32'd1);
    wr_en_i = 1'b0; col_i = '0;
    step();
    check("rej_none_err_clr", 32'(err_o), 32'd0);

    // wr_en_i low ignores bad inputs.
    row_n_i = 7'b1111100; col_i = 5'b00000;
    step();
    check("idle_no_err", 32'(err_o), 32'd0);
    row_n_i = '1;

    // Last row of frame 0, wrap to row 0, row 0 untouched by the rejects.
    goTo(168); checkOut("row6_drive_last", 7'h3F, 5'b00000);
    goTo(169); checkOut("wrap_row0_blank", 7'h7F, 5'b00000);
    goTo(173); checkOut("row0_kept", 7'h7E, 5'b00110);

    // Fill all seven rows with distinct codes.
    for (int r = 0; r < NR - 1; r++) writeRow(r, codes[r]);
    check("six_rows_full", 32'(frame_full_o), 32'd0);
    writeRow(NR - 1, codes[NR - 1]);
    check("seven_rows_full", 32'(frame_full_o), 32'd1);

    // Frame 2 shows rows 0..6 in order, mid-DRIVE of each slot.
    for (int r = 0; r < NR; r++) begin
      goTo(347 + SD * r);
      checkOut($sformatf("frame_row%0d", r), ~(7'(1) << r), codes[r]);
    end

    // Clear wins over a same-cycle write and raises no error.
    clear_i = 1'b1; wr_en_i = 1'b1; row_n_i = 7'b1111110; col_i = 5'b11111;
    step();
    clear_i = 1'b0; wr_en_i = 1'b0; row_n_i = '1; col_i = '0;
    check("clear_full", 32'(frame_full_o), 32'd0);
    check("clear_err", 32'(err_o), 32'd0);
    goTo(505); checkOut("clear_row0_blank", 7'h7F, 5'b00000);
    goTo(509); checkOut("clear_row0_empty", 7'h7E, 5'b00000);

    // Reset in the middle of row 3's DRIVE window.
    writeRow(3, 5'b01000);
    goTo(590); checkOut("row3_drive", 7'h77, 5'b01000);
    rst_n = 1'b0;
    step();
    checkOut("midscan_reset", 7'h7F, 5'b00000);
    check("midscan_reset_full", 32'(frame_full_o), 32'd0);
    rst_n = 1'b1;
    n     = 0;
    goTo(4);  checkOut("restart_blank", 7'h7F, 5'b00000);
    goTo(5);  checkOut("restart_row0", 7'h7E, 5'b00000);
    goTo(77); checkOut("restart_row3_empty", 7'h77, 5'b00000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
